varredura_display: RTL and testbench
====================================

VARREDURA_DISPLAY -- requirements
Module: varredura_display

Interface
REQ-001 Parameter DIV_REFRESH, default 50000, SHALL set the clock cycles each digit slot is lit (legal range 2..2^20).
REQ-002 Parameter TEMPO_APAGADO, default 500, SHALL set the blank cycles between slots (legal range 0..2^16-1).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 valor  input  16  SHALL carry four nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-006 carregar  input  1  SHALL be a load strobe; while high, valor is latched into the internal display register.
REQ-007 habilita_digitos  input  4  SHALL be a per-digit enable mask; bit n low blanks digit n.
REQ-008 anodo  output  4  SHALL be one-hot digit select, active-high, registered.
REQ-009 saida_seg  output  7  SHALL be segments {a..g}, active-high (1 = lit), registered.

Function
REQ-010 FSM states SHALL be EXIBE (slot lit) and APAGA (inter-digit blank).
REQ-011 In EXIBE, a slot counter SHALL count 0..DIV_REFRESH-1; at terminal count the FSM SHALL go to APAGA, or to EXIBE of the next digit if TEMPO_APAGADO=0.
REQ-012 In APAGA, anodo SHALL be 4'b0000 and saida_seg 7'b0000000 for exactly TEMPO_APAGADO cycles, then EXIBE of the next digit.
REQ-013 The digit index SHALL advance 0->1->2->3->0 and wrap without a gap.
REQ-014 In EXIBE for digit n, anodo SHALL equal (1<<n) when habilita_digitos[n]=1, else 4'b0000; slot duration SHALL be unchanged by the mask.
REQ-015 saida_seg SHALL be the hex pattern of the selected register nibble (0..F, including A,b,C,d,E,F), or 7'b0000000 when the digit is blanked.
REQ-016 anodo and saida_seg SHALL change on the same clock edge; no cycle may show a new anode with an old pattern.
REQ-017 carregar SHALL take effect on the edge it is sampled; the new value SHALL appear on saida_seg one cycle later, mid-slot if applicable.
REQ-018 carregar coincident with a slot change SHALL show the new value in the new slot.
REQ-019 habilita_digitos SHALL be sampled every cycle, with no latching.
REQ-020 The slot counter SHALL be ceil(log2(DIV_REFRESH)) bits wide, and the blank counter ceil(log2(TEMPO_APAGADO+1)) bits wide (minimum 1).

Reset
REQ-021 rst SHALL force the FSM to EXIBE, digit index 0, both counters 0, display register 16'h0000, anodo 4'b0000, and saida_seg 7'b0000000.
REQ-022 In the first cycle after rst falls, anodo SHALL be 4'b0001 (if enabled) and saida_seg the pattern for 0, 7'b1111110.
REQ-023 rst asserted mid-slot or mid-blank SHALL take effect on the next edge, with no completion of the current slot.
REQ-024 rst SHALL take priority over carregar in the same cycle.

Configuration
REQ-025 Macro SUPRIME_ZEROS_EN, when defined, SHALL blank digit n (n>=1) if nibble n and all higher nibbles are zero; digit 0 is never suppressed.
REQ-026 Without SUPRIME_ZEROS_EN, all enabled digits SHALL display, including leading zeros.
REQ-027 Suppression SHALL apply after the mask and leave slot timing unchanged.

Structure
REQ-028 Shared package SHALL hold NUM_DIGITOS=4, LARGURA_NIBBLE=4, LARGURA_SEG=7, and the FSM state encoding.
REQ-029 The block SHALL instantiate one HexPara7Seg for nibble-to-segment conversion and register its output.

Verification
(DIV_REFRESH=4, TEMPO_APAGADO=1 for all scenarios.)
REQ-030 rst, then valor=16'h1A3F with carregar -> anodo 0001 x4 with seg 1000111 (F), 0000 x1, 0010 x4 with seg 1111001 (3), 0000 x1, 0100 x4 with seg 1110111 (A), 0000 x1, 1000 x4 with seg 0110000 (1).
REQ-031 Run past digit 3 -> after its blank cycle, anodo 0001 returns; period is 20 cycles.
REQ-032 habilita_digitos=4'b1010 -> anodo never asserts bits 0 or 2; the 20-cycle period is unchanged.
REQ-033 valor 16'h0001 to 16'h0002 via carregar in cycle 2 of the digit-0 slot -> seg changes 0110000 to 1101101 next cycle; anodo stays 0001.
REQ-034 valor=16'h0040 -> with SUPRIME_ZEROS_EN, digits 3 and 2 are dark and digits 1 and 0 show 4 and 0; without the macro, all four digits are lit.
REQ-035 rst pulsed during the digit-2 slot -> anodo 0000 and seg 0000000 next cycle; after release, the display restarts at digit 0 showing 0.

Source files
------------

// File: rtl/varredura_display_pkg.sv
// varredura_display_pkg: shared widths and FSM state encoding for the 4-digit display scanner
package varredura_display_pkg;
    localparam int NUM_DIGITOS    = 4;
    localparam int LARGURA_NIBBLE = 4;
    localparam int LARGURA_SEG    = 7;
    localparam int LARGURA_IDX    = $clog2(NUM_DIGITOS);
    typedef enum logic {EXIBE = 1'b0, APAGA = 1'b1} estado_t;
endpackage

// File: rtl/varredura_display_hex.sv
// HexPara7Seg: combinational hex nibble to active-high {a..g} segment pattern
module HexPara7Seg
    import varredura_display_pkg::*;
(
    input  logic [LARGURA_NIBBLE-1:0] nibble,
    output logic [LARGURA_SEG-1:0]    seg
);
    always_comb begin
        seg = '0;
        case (nibble)
            4'h0: seg = 7'b1111110;
            4'h1: seg = 7'b0110000;
            4'h2: seg = 7'b1101101;
            4'h3: seg = 7'b1111001;
            4'h4: seg = 7'b0110011;
            4'h5: seg = 7'b1011011;
            4'h6: seg = 7'b1011111;
            4'h7: seg = 7'b1110000;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1111011;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b0011111;
            4'hC: seg = 7'b1001110;
            4'hD: seg = 7'b0111101;
            4'hE: seg = 7'b1001111;
            4'hF: seg = 7'b1000111;
            default: seg = '0;
        endcase
    end
endmodule

// File: rtl/varredura_display.sv
// varredura_display: time-multiplexed 4-digit hex display scanner with inter-digit blanking.
// Optional leading-zero suppression when SUPRIME_ZEROS_EN is defined.
module varredura_display
    import varredura_display_pkg::*;
#(
    parameter int DIV_REFRESH   = 50000,
    parameter int TEMPO_APAGADO = 500
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            valor,
    input  logic                   carregar,
    input  logic [NUM_DIGITOS-1:0] habilita_digitos,
    output logic [NUM_DIGITOS-1:0] anodo,
    output logic [LARGURA_SEG-1:0] saida_seg
);
    localparam int LS = (DIV_REFRESH > 1) ? $clog2(DIV_REFRESH) : 1;
    localparam int LB = (TEMPO_APAGADO > 0) ? $clog2(TEMPO_APAGADO + 1) : 1;
    localparam logic [LS-1:0] FIM_S = LS'(DIV_REFRESH - 1);
    localparam logic [LB-1:0] FIM_B = LB'((TEMPO_APAGADO > 0) ? TEMPO_APAGADO - 1 : 0);

    estado_t                estado, estado_n;
    logic [LS-1:0]          cnt_s, cnt_s_n;
    logic [LB-1:0]          cnt_b, cnt_b_n;
    logic [LARGURA_IDX-1:0] idx, idx_n;
    logic [15:0]            reg_valor, reg_valor_n;
    logic [NUM_DIGITOS-1:0] anodo_n;
    logic [LARGURA_SEG-1:0] seg_n, seg_hex;
    logic [LARGURA_NIBBLE-1:0] nibble;
    logic fim_s, fim_b, supr, aceso;

    assign nibble = reg_valor[idx*LARGURA_NIBBLE +: LARGURA_NIBBLE];

`ifdef SUPRIME_ZEROS_EN
    assign supr = (idx != '0) && ((reg_valor >> (idx * LARGURA_NIBBLE)) == '0);
`else
    assign supr = 1'b0;
`endif

    HexPara7Seg u_hex (.nibble(nibble), .seg(seg_hex));

    always_comb begin
        fim_s       = (estado == EXIBE) && (cnt_s == FIM_S);
        fim_b       = (estado == APAGA) && (cnt_b == FIM_B);
        estado_n    = (fim_s && TEMPO_APAGADO != 0) ? APAGA : fim_b ? EXIBE : estado;
        idx_n       = ((fim_s && TEMPO_APAGADO == 0) || fim_b) ? idx + LARGURA_IDX'(1) : idx;
        cnt_s_n     = (estado != EXIBE || fim_s) ? '0 : cnt_s + LS'(1);
        cnt_b_n     = (estado != APAGA || fim_b) ? '0 : cnt_b + LB'(1);
        reg_valor_n = carregar ? valor : reg_valor;
        // Mask and suppression only gate the outputs, never the scan timing
        aceso       = (estado == EXIBE) && habilita_digitos[idx] && !supr;
        anodo_n     = aceso ? (NUM_DIGITOS'(1) << idx) : '0;
        seg_n       = aceso ? seg_hex : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado    <= EXIBE;
            cnt_s     <= '0;
            cnt_b     <= '0;
            idx       <= '0;
            reg_valor <= '0;
            anodo     <= '0;
            saida_seg <= '0;
        end else begin
            estado    <= estado_n;
            cnt_s     <= cnt_s_n;
            cnt_b     <= cnt_b_n;
            idx       <= idx_n;
            reg_valor <= reg_valor_n;
            anodo     <= anodo_n;
            saida_seg <= seg_n;
        end
    end
endmodule

// File: tb/tb_varredura_display.sv
// tb_varredura_display: directed + random scan checks against a position-based display model
module tb_varredura_display;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        carregar = 1'b0;
    logic [15:0] valor = '0;
    logic [3:0]  habilita_digitos = 4'hF;
    logic [3:0]  anodo;
    logic [6:0]  saida_seg;

    int checks = 0;
    int errors = 0;
    int p = 0;
    logic [15:0] vreg = '0;
    logic [6:0] tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    always #5 clk = ~clk;

    varredura_display #(.DIV_REFRESH(4), .TEMPO_APAGADO(1)) dut (
        .clk(clk), .rst(rst), .valor(valor), .carregar(carregar),
        .habilita_digitos(habilita_digitos), .anodo(anodo), .saida_seg(saida_seg)
    );

    function automatic logic suprime(input logic [15:0] v, input int d);
`ifdef SUPRIME_ZEROS_EN
        return d > 0 && (v >> (4 * d)) == 16'h0;
`else
        return 1'b0;
`endif
    endfunction

    // Scan position p counts cycles since reset: 20-cycle frame, 5 per digit, last one blank
    task automatic step(input logic r, input logic ld, input logic [15:0] v, input logic [3:0] m);
        logic [3:0] ea;
        logic [6:0] es;
        logic       lit;
        int         d;
        rst = r;
        carregar = ld;
        valor = v;
        habilita_digitos = m;
        d = (p % 20) / 5;
        lit = !r && (p % 5) < 4 && m[d] && !suprime(vreg, d);
        ea = lit ? 4'(1 << d) : 4'b0000;
        es = lit ? tab[vreg[4*d +: 4]] : 7'b0000000;
        @(posedge clk);
        #1;
        checks++;
        assert (anodo === ea) else begin
            errors++;
            $error("FAIL anodo p=%0d observed=%b expected=%b", p, anodo, ea);
        end
        checks++;
        assert (saida_seg === es) else begin
            errors++;
            $error("FAIL saida_seg p=%0d observed=%b expected=%b", p, saida_seg, es);
        end
        if (r) begin
            p = 0;
            vreg = '0;
        end else begin
            p++;
            if (ld) vreg = v;
        end
    endtask

    initial begin
        logic [3:0] m;
        repeat (2) step(1'b1, 1'b1, 16'hFFFF, 4'hF);
        step(1'b0, 1'b1, 16'h1A3F, 4'hF);
        repeat (44) step(1'b0, 1'b0, 16'h0, 4'hF);
        repeat (40) step(1'b0, 1'b0, 16'h0, 4'b1010);
        step(1'b1, 1'b0, 16'h0, 4'hF);
        step(1'b0, 1'b1, 16'h0001, 4'hF);
        step(1'b0, 1'b1, 16'h0002, 4'hF);
        repeat (10) step(1'b0, 1'b0, 16'h0, 4'hF);
        step(1'b0, 1'b1, 16'h0040, 4'hF);
        repeat (22) step(1'b0, 1'b0, 16'h0, 4'hF);
        for (int i = 0; i < 20 && !((p % 20) / 5 == 2 && p % 5 == 1); i++)
            step(1'b0, 1'b0, 16'h0, 4'hF);
        step(1'b1, 1'b0, 16'h0, 4'hF);
        repeat (6) step(1'b0, 1'b0, 16'h0, 4'hF);
        m = 4'hF;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(15) == 0) m = 4'($urandom);
            step($urandom_range(99) == 0, $urandom_range(7) == 0, 16'($urandom), m);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
